// File: rtl/quad_decoder.sv
// Quadrature encoder front end: 2-flop sync, per-channel glitch filter, X4 decode, illegal detect.
// Define QDEC_ERR_CNT_EN to add the 8-bit saturating err_cnt output.
module quad_decoder #(
   parameter int unsigned FILT_LEN = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       a_in,
   input  logic       b_in,
   input  logic       err_clr,
   output logic       step_en,
   output logic       dir,
   output logic       err
`ifdef QDEC_ERR_CNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   localparam int unsigned CntW  = $clog2(FILT_LEN + 1);
   localparam int unsigned InitW = $clog2(FILT_LEN + 3);
   localparam logic [CntW-1:0]  CntMax  = CntW'(FILT_LEN - 1);
   localparam logic [InitW-1:0] InitLen = InitW'(FILT_LEN + 2);

   // Bit 1 is channel A, bit 0 is channel B, so every vector reads as the {A,B} state.
   logic [1:0]           sync1, sync2, filt, prev;
   logic [1:0][CntW-1:0] cnt;
   logic [InitW-1:0]     init_cnt;
   logic                 init, legal, illegal, fwd;
   logic [1:0]           delta;

   assign init    = (init_cnt != InitLen);
   assign delta   = prev ^ filt;
   assign legal   = (delta == 2'b01) || (delta == 2'b10);
   assign illegal = (delta == 2'b11);
   // Forward (00->10->11->01->00) is exactly when the new A differs from the old B.
   assign fwd     = filt[1] ^ prev[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1    <= '0;
         sync2    <= '0;
         filt     <= '0;
         prev     <= '0;
         cnt      <= '0;
         init_cnt <= '0;
         step_en  <= 1'b0;
         dir      <= 1'b0;
         err      <= 1'b0;
      end else begin
         sync1 <= {a_in, b_in};
         sync2 <= sync1;
         prev  <= filt;
         if (init) begin
            // Track the pins unfiltered until the pipeline holds real data.
            init_cnt <= init_cnt + InitW'(1);
            filt     <= sync2;
            cnt      <= '0;
            step_en  <= 1'b0;
            err      <= 1'b0;
         end else begin
            for (int i = 0; i < 2; i++) begin
               if (sync2[i] == filt[i]) begin
                  cnt[i] <= '0;
               end else if (cnt[i] == CntMax) begin
                  filt[i] <= sync2[i];
                  cnt[i]  <= '0;
               end else begin
                  cnt[i] <= cnt[i] + CntW'(1);
               end
            end
            step_en <= legal;
            if (legal) begin
               dir <= fwd;
            end
            if (illegal) begin
               err <= 1'b1;
            end else if (err_clr) begin
               err <= 1'b0;
            end
         end
      end
   end

`ifdef QDEC_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt <= '0;
      end else if (!init && illegal) begin
         if (err_clr) begin
            err_cnt <= 8'd1;
         end else if (err_cnt != 8'hff) begin
            err_cnt <= err_cnt + 8'd1;
         end
      end else if (err_clr) begin
         err_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: expected step pulses are queued at pin-change time
// and matched against the step pulses seen on the outputs.
module tb_quad_decoder;
   localparam int unsigned FILT_LEN = 4;
   localparam int unsigned LAT      = FILT_LEN + 3;

   typedef struct {
      int unsigned cyc;
      logic        dir;
   } step_t;

   logic clk = 1'b0;
   logic reset, a_in, b_in, err_clr;
   logic step_en, dir, err;
`ifdef QDEC_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   step_t       exp_q[$];
   step_t       obs_q[$];
   step_t       mon_s;

   quad_decoder #(
      .FILT_LEN(FILT_LEN)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .a_in    (a_in),
      .b_in    (b_in),
      .err_clr (err_clr),
      .step_en (step_en),
      .dir     (dir),
      .err     (err)
`ifdef QDEC_ERR_CNT_EN
      ,
      .err_cnt (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (step_en === 1'b1) begin
         mon_s.cyc = cyc;
         mon_s.dir = dir;
         obs_q.push_back(mon_s);
      end
   end

   task automatic hold(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive the pins; a legal change is expected to pulse step_en LAT edges later.
   task automatic drive(input logic a, input logic b, input bit exp_step, input logic exp_dir);
      step_t e;
      a_in = a;
      b_in = b;
      if (exp_step) begin
         e.cyc = cyc + LAT;
         e.dir = exp_dir;
         exp_q.push_back(e);
      end
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      a_in    = 1'b1;
      b_in    = 1'b1;
      err_clr = 1'b0;
      hold(3);
      checks++;
      if (step_en !== 1'b0 || dir !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: step_en=%b dir=%b err=%b, required 0 0 0",
                  step_en, dir, err);
      end
`ifdef QDEC_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL reset_err_cnt: got %0d, required 0", err_cnt);
      end
`endif
      reset = 1'b0;
      hold(FILT_LEN + 2);
      checks++;
      if (dut.filt !== 2'b11) begin
         errors++;
         $display("FAIL init_filt: got %b, required 11", dut.filt);
      end
      hold(8);
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL init_step: %0d step_en pulses, required 0", obs_q.size());
         obs_q.delete();
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL init_err: got %b, required 0", err);
      end
   endtask

   task automatic test_forward();
      step_t e, o;
      drive(1'b0, 1'b1, 1'b1, 1'b1); hold(10);
      drive(1'b0, 1'b0, 1'b1, 1'b1); hold(10);
      drive(1'b1, 1'b0, 1'b1, 1'b1); hold(10);
      drive(1'b1, 1'b1, 1'b1, 1'b1); hold(10);
      drive(1'b0, 1'b1, 1'b1, 1'b1); hold(10);
      drive(1'b0, 1'b0, 1'b1, 1'b1); hold(10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL fwd_step: no pulse, required cycle %0d dir=%b", e.cyc, e.dir);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.dir !== e.dir) begin
               errors++;
               $display("FAIL fwd_step: got cycle %0d dir=%b, required cycle %0d dir=%b",
                        o.cyc, o.dir, e.cyc, e.dir);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0 || dir !== 1'b1) begin
         errors++;
         $display("FAIL fwd_end: extra pulses=%0d dir=%b, required 0 and 1", obs_q.size(), dir);
         obs_q.delete();
      end
   endtask

   task automatic test_reverse();
      step_t e, o;
      drive(1'b0, 1'b1, 1'b1, 1'b0); hold(10);
      drive(1'b1, 1'b1, 1'b1, 1'b0); hold(10);
      drive(1'b1, 1'b0, 1'b1, 1'b0); hold(10);
      drive(1'b0, 1'b0, 1'b1, 1'b0); hold(10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL rev_step: no pulse, required cycle %0d dir=%b", e.cyc, e.dir);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.dir !== e.dir) begin
               errors++;
               $display("FAIL rev_step: got cycle %0d dir=%b, required cycle %0d dir=%b",
                        o.cyc, o.dir, e.cyc, e.dir);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0 || dir !== 1'b0) begin
         errors++;
         $display("FAIL rev_end: extra pulses=%0d dir=%b, required 0 and 0", obs_q.size(), dir);
         obs_q.delete();
      end
   endtask

   task automatic test_glitch();
      step_t e, o;
      drive(1'b1, 1'b0, 1'b0, 1'b0); hold(FILT_LEN - 1);
      drive(1'b0, 1'b0, 1'b0, 1'b0); hold(15);
      checks++;
      if (obs_q.size() != 0 || dut.filt !== 2'b00) begin
         errors++;
         $display("FAIL glitch_short: pulses=%0d filt=%b, required 0 and 00",
                  obs_q.size(), dut.filt);
         obs_q.delete();
      end
      drive(1'b1, 1'b0, 1'b1, 1'b1); hold(FILT_LEN);
      drive(1'b0, 1'b0, 1'b1, 1'b0); hold(15);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL glitch_step: no pulse, required cycle %0d dir=%b", e.cyc, e.dir);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.dir !== e.dir) begin
               errors++;
               $display("FAIL glitch_step: got cycle %0d dir=%b, required cycle %0d dir=%b",
                        o.cyc, o.dir, e.cyc, e.dir);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL glitch_extra: %0d pulses, required 0", obs_q.size());
         obs_q.delete();
      end
   endtask

   task automatic test_illegal();
      logic v;
      drive(1'b1, 1'b1, 1'b0, 1'b0); hold(10);
      checks++;
      if (err !== 1'b1 || dir !== 1'b0 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL illegal_first: err=%b dir=%b pulses=%0d, required 1 0 0",
                  err, dir, obs_q.size());
         obs_q.delete();
      end
`ifdef QDEC_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL illegal_cnt1: got %0d, required 1", err_cnt);
      end
`endif
      err_clr = 1'b1; hold(1); err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clr: err=%b, required 0", err);
      end
`ifdef QDEC_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL err_clr_cnt: got %0d, required 0", err_cnt);
      end
`endif
      for (int i = 0; i < 300; i++) begin
         v = (i % 2 == 1);
         drive(v, v, 1'b0, 1'b0);
         hold(FILT_LEN + 4);
      end
      checks++;
      if (err !== 1'b1 || obs_q.size() != 0) begin
         errors++;
         $display("FAIL illegal_many: err=%b pulses=%0d, required 1 0", err, obs_q.size());
         obs_q.delete();
      end
`ifdef QDEC_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'd255) begin
         errors++;
         $display("FAIL err_cnt_sat: got %0d, required 255", err_cnt);
      end
`endif
      // Clear lands on the very edge the 11->00 illegal transition is decoded.
      drive(1'b0, 1'b0, 1'b0, 1'b0); hold(LAT - 1);
      err_clr = 1'b1; hold(1); err_clr = 1'b0;
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL clr_vs_set: err=%b, required 1", err);
      end
`ifdef QDEC_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'd1) begin
         errors++;
         $display("FAIL clr_vs_set_cnt: got %0d, required 1", err_cnt);
      end
`endif
      hold(3);
      err_clr = 1'b1; hold(1); err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clr2: err=%b, required 0", err);
      end
   endtask

   task automatic test_reset_mid();
      step_t e, o;
      drive(1'b1, 1'b0, 1'b1, 1'b1); hold(10);
      drive(1'b0, 1'b1, 1'b0, 1'b0); hold(10);
      checks++;
      if (dir !== 1'b1 || err !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: dir=%b err=%b, required 1 1", dir, err);
      end
      // Filter count for A reaches 2 right before the reset edge.
      drive(1'b1, 1'b1, 1'b0, 1'b0); hold(4);
      reset = 1'b1; hold(1);
      checks++;
      if (step_en !== 1'b0 || dir !== 1'b0 || err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: step_en=%b dir=%b err=%b, required 0 0 0",
                  step_en, dir, err);
      end
`ifdef QDEC_ERR_CNT_EN
      checks++;
      if (err_cnt !== 8'd0) begin
         errors++;
         $display("FAIL mid_reset_cnt: got %0d, required 0", err_cnt);
      end
`endif
      reset = 1'b0;
      exp_q.pop_front();
      while (obs_q.size() > 1) void'(obs_q.pop_back());
      // The 10 step was observed before reset; keep only the pre-reset pulse for matching.
      hold(FILT_LEN + 2);
      checks++;
      if (dut.filt !== 2'b11) begin
         errors++;
         $display("FAIL mid_init_filt: got %b, required 11", dut.filt);
      end
      hold(10);
      checks++;
      if (obs_q.size() != 1) begin
         errors++;
         $display("FAIL mid_init_step: %0d pulses, required 1 (pre-reset only)", obs_q.size());
      end
      obs_q.delete();
      drive(1'b0, 1'b1, 1'b1, 1'b1); hold(10);
      drive(1'b0, 1'b0, 1'b1, 1'b1); hold(10);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if (obs_q.size() == 0) begin
            errors++;
            $display("FAIL resume_step: no pulse, required cycle %0d dir=%b", e.cyc, e.dir);
         end else begin
            o = obs_q.pop_front();
            if (o.cyc !== e.cyc || o.dir !== e.dir) begin
               errors++;
               $display("FAIL resume_step: got cycle %0d dir=%b, required cycle %0d dir=%b",
                        o.cyc, o.dir, e.cyc, e.dir);
            end
         end
      end
      checks++;
      if (obs_q.size() != 0 || err !== 1'b0) begin
         errors++;
         $display("FAIL resume_end: pulses=%0d err=%b, required 0 0", obs_q.size(), err);
         obs_q.delete();
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_glitch();
      test_illegal();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
